pooled_feature_serializer: RTL and testbench

- Sits directly downstream of the pooling layer.
- Captures each valid pooled pixel vector (CHANNELS x 16-bit words, all channels in parallel) into a small FIFO.
- Emits the words one channel per cycle over a valid/ready stream to the fully connected stage.
- Marks the final word of each pooled feature map with out_last.
- The pooling layer has no back-pressure, so overflow is flagged rather than stalled.

---
 rtl/pooled_feature_serializer_pkg.sv | 15 +
 rtl/pooled_feature_serializer_pixel_fifo.sv | 55 +++++
 rtl/pooled_feature_serializer.sv | 96 +++++++++
 tb/tb_pooled_feature_serializer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pooled_feature_serializer_pkg.sv
// rtl/pooled_feature_serializer_pkg.sv - shared widths and helpers for the pooled feature serializer
`ifndef LOG2
`define LOG2(x) $clog2(x)
`endif

package pooled_feature_serializer_pkg;

  localparam int DATA_WIDTH = 16;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pooled_feature_serializer_pixel_fifo.sv
// rtl/pooled_feature_serializer_pixel_fifo.sv - synchronous FIFO of whole pooled pixel vectors
`ifndef LOG2
`define LOG2(x) $clog2(x)
`endif

module pooled_feature_serializer_pixel_fifo
  import pooled_feature_serializer_pkg::*;
#(
  parameter int WIDTH = 80,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = cnt_width(DEPTH);
  localparam int CNT_W = `LOG2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/pooled_feature_serializer.sv
// rtl/pooled_feature_serializer.sv - buffers pooled pixel vectors and streams them one channel word per cycle
`ifndef LOG2
`define LOG2(x) $clog2(x)
`endif

module pooled_feature_serializer
  import pooled_feature_serializer_pkg::*;
#(
  parameter int CHANNELS   = 5,
  parameter int OUT_SIZE   = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clk_en,
  input  logic [DATA_WIDTH*CHANNELS-1:0] in_data,
  input  logic                           in_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [`LOG2(CHANNELS)-1:0]     out_channel,
  output logic                           out_last,
  output logic                           overflow
);

  localparam int CH_W   = `LOG2(CHANNELS);
  localparam int PIXELS = OUT_SIZE * OUT_SIZE;
  localparam int PIX_W  = cnt_width(PIXELS);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXELS - 1);

  logic [DATA_WIDTH*CHANNELS-1:0] w_head;
  logic                           w_full;
  logic                           w_empty;
  logic                           w_capture;
  logic                           w_hs;
  logic                           w_pop;
  logic                           w_push;

  logic [CH_W-1:0]  r_chan_idx;
  logic [PIX_W-1:0] r_pix_cnt;
  logic             r_overflow;

  assign w_capture = in_valid && clk_en;
  assign w_hs      = !w_empty && out_ready;
  assign w_pop     = w_hs && (r_chan_idx == LAST_CH);
  // A full FIFO still accepts when the head frees its slot on the same edge.
  assign w_push    = w_capture && (!w_full || w_pop);

  pooled_feature_serializer_pixel_fifo #(
    .WIDTH (DATA_WIDTH * CHANNELS),
    .DEPTH (FIFO_DEPTH)
  ) u_pixel_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chan_idx <= '0;
      r_pix_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_hs) begin
        if (r_chan_idx == LAST_CH) begin
          r_chan_idx <= '0;
          r_pix_cnt  <= (r_pix_cnt == LAST_PIX) ? '0 : r_pix_cnt + 1'b1;
        end else begin
          r_chan_idx <= r_chan_idx + 1'b1;
        end
      end
      if (w_capture && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    out_data = '0;
    if (!w_empty) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (r_chan_idx == CH_W'(i)) out_data = w_head[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_valid   = !w_empty;
  assign out_channel = r_chan_idx;
  assign out_last    = (r_pix_cnt == LAST_PIX) && (r_chan_idx == LAST_CH) && !w_empty;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_pooled_feature_serializer.sv
// tb/tb_pooled_feature_serializer.sv - scoreboard bench for the pooled feature serializer
module tb_pooled_feature_serializer;

  localparam int CH = 5;
  localparam int OS = 2;
  localparam int FD = 2;
  localparam int PIX = OS * OS;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  ch;
    logic        last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_en;
  logic [79:0]   in_data;
  logic          in_valid;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_channel;
  logic          out_last;
  logic          overflow;

  exp_t sb[$];
  int   tb_pix;
  int   n_last_seen;
  int   n_checks;
  int   n_err;

  pooled_feature_serializer #(
    .CHANNELS   (CH),
    .OUT_SIZE   (OS),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel),
    .out_last    (out_last),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Every accepted word is compared against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_word: got data=%0d ch=%0d last=%0d, expected no word", out_data, out_channel, out_last);
      end else if (out_ready) begin
        e = sb.pop_front();
        n_checks++;
        if (out_data !== e.data || out_channel !== e.ch || out_last !== e.last) begin
          n_err++;
          $display("FAIL word: got data=%0d ch=%0d last=%0d, expected data=%0d ch=%0d last=%0d",
                   out_data, out_channel, out_last, e.data, e.ch, e.last);
        end
        if (out_last === 1'b1) n_last_seen++;
      end
    end
  end

  function automatic logic [79:0] rand_pixel();
    logic [79:0] r;
    for (int c = 0; c < CH; c++) r[c*16 +: 16] = 16'($urandom());
    return r;
  endfunction

  task automatic apply_reset();
    in_valid = 1'b0;
    clk_en   = 1'b1;
    rst_n    = 1'b0;
    sb.delete();
    tb_pix      = 0;
    n_last_seen = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive_pixel(input logic [79:0] d, input bit accept);
    exp_t e;
    in_data  = d;
    in_valid = 1'b1;
    if (accept) begin
      for (int c = 0; c < CH; c++) begin
        e.data = d[c*16 +: 16];
        e.ch   = 3'(c);
        e.last = (tb_pix == PIX - 1) && (c == CH - 1);
        sb.push_back(e);
      end
      tb_pix = (tb_pix + 1) % PIX;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0)   begin n_err++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
    n_checks++; if (out_channel !== 3'd0) begin n_err++; $display("FAIL reset_channel: got %0d, expected 0", out_channel); end
    n_checks++; if (out_last !== 1'b0)    begin n_err++; $display("FAIL reset_last: got %b, expected 0", out_last); end
    n_checks++; if (overflow !== 1'b0)    begin n_err++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
    n_checks++; if (out_data !== 16'd0)   begin n_err++; $display("FAIL reset_data: got %0d, expected 0", out_data); end
    apply_reset();
  endtask

  task automatic test_single_pixel();
    int cnt;
    int first;
    int lastk;
    apply_reset();
    out_ready = 1'b1;
    drive_pixel({16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
    cnt = 0; first = -1; lastk = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (k == 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_channel !== 3'd0) begin
          n_err++; $display("FAIL first_latency: got valid=%b ch=%0d, expected valid=1 ch=0", out_valid, out_channel);
        end
      end
      if (out_valid === 1'b1) begin cnt++; lastk = k; if (first < 0) first = k; end
    end
    n_checks++; if (cnt != 5 || first != 0 || lastk != 4) begin
      n_err++; $display("FAIL single_burst: got %0d words first=%0d last=%0d, expected 5 words at 0..4", cnt, first, lastk);
    end
    n_checks++; if (sb.size() != 0) begin n_err++; $display("FAIL single_drain: got %0d pending, expected 0", sb.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_map_last();
    apply_reset();
    out_ready = 1'b1;
    for (int p = 0; p < PIX + 1; p++) begin
      drive_pixel(rand_pixel(), 1'b1);
      repeat (5) begin @(posedge clk); #1; end
    end
    for (int k = 0; k < 100 && sb.size() != 0; k++) begin @(negedge clk); #1; end
    n_checks++; if (sb.size() != 0) begin n_err++; $display("FAIL map_drain: got %0d pending, expected 0", sb.size()); end
    n_checks++; if (n_last_seen != 1) begin n_err++; $display("FAIL map_last_count: got %0d, expected 1", n_last_seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [79:0] d;
    apply_reset();
    out_ready = 1'b1;
    d = rand_pixel();
    drive_pixel(d, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_channel !== 3'd2 || out_data !== d[47:32]) begin
        n_err++; $display("FAIL stall_hold: got valid=%b ch=%0d data=%0d, expected valid=1 ch=2 data=%0d",
                          out_valid, out_channel, out_data, d[47:32]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() != 0; k++) begin @(negedge clk); #1; end
    n_checks++; if (sb.size() != 0) begin n_err++; $display("FAIL stall_drain: got %0d pending, expected 0", sb.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    apply_reset();
    out_ready = 1'b0;
    drive_pixel(rand_pixel(), 1'b1);
    drive_pixel(rand_pixel(), 1'b1);
    drive_pixel(rand_pixel(), 1'b0);
    n_checks++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_set: got %b, expected 1", overflow); end
    n_checks++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL overflow_valid: got %b, expected 1", out_valid); end
    out_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() != 0; k++) begin @(negedge clk); #1; end
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if (sb.size() != 0) begin n_err++; $display("FAIL overflow_drain: got %0d pending, expected 0", sb.size()); end
    n_checks++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_sticky: got %b, expected 1", overflow); end
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL overflow_empty: got %b, expected 0", out_valid); end
  endtask

  task automatic test_full_pop();
    apply_reset();
    out_ready = 1'b0;
    drive_pixel(rand_pixel(), 1'b1);
    drive_pixel(rand_pixel(), 1'b1);
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    drive_pixel(rand_pixel(), 1'b1);
    n_checks++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pop_overflow: got %b, expected 0", overflow); end
    for (int k = 0; k < 50 && sb.size() != 0; k++) begin @(negedge clk); #1; end
    n_checks++; if (sb.size() != 0) begin n_err++; $display("FAIL full_pop_drain: got %0d pending, expected 0", sb.size()); end
    n_checks++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pop_final_overflow: got %b, expected 0", overflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_clk_en();
    apply_reset();
    out_ready = 1'b1;
    clk_en = 1'b0;
    drive_pixel(rand_pixel(), 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clk_en_gate: got valid=%b, expected 0", out_valid); end
    clk_en = 1'b1;
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    out_ready = 1'b0;
    drive_pixel(rand_pixel(), 1'b1);
    drive_pixel(rand_pixel(), 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_channel !== 3'd0) begin
      n_err++; $display("FAIL async_reset: got valid=%b ch=%0d, expected valid=0 ch=0", out_valid, out_channel);
    end
    sb.delete();
    tb_pix      = 0;
    n_last_seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int p = 0; p < PIX; p++) begin
      drive_pixel(rand_pixel(), 1'b1);
      repeat (5) begin @(posedge clk); #1; end
    end
    for (int k = 0; k < 100 && sb.size() != 0; k++) begin @(negedge clk); #1; end
    n_checks++; if (sb.size() != 0) begin n_err++; $display("FAIL restart_drain: got %0d pending, expected 0", sb.size()); end
    n_checks++; if (n_last_seen != 1) begin n_err++; $display("FAIL restart_last_count: got %0d, expected 1", n_last_seen); end
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    tb_pix    = 0;
    n_last_seen = 0;
    rst_n     = 1'b0;
    clk_en    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_pixel();
    test_map_last();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_clk_en();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
